alu_issue_ctrl: RTL

- Sequential initiator for the combinational ALU (`ALU` instance, `BUS_SIZE` wide).
- Accepts operation commands over a valid/ready interface and registers operands onto the ALU port group (operation, p1, p2, carry-in).
- Captures the ALU result and flags, returns them over a valid/ready response channel, and keeps sticky status flags for the core.

---
 rtl/alu_issue_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// Sequential issue controller for a combinational ALU: registers the operand
// drive, waits one settle cycle, captures the result and returns it over valid/ready.
`ifndef ALU_FLAG_COUNT
`define ALU_FLAG_COUNT 4
`endif
`ifndef ALU_FLAG_ZERO
`define ALU_FLAG_ZERO 0
`endif
`ifndef ALU_FLAG_CARRY
`define ALU_FLAG_CARRY 1
`endif
`ifndef ALU_FLAG_OVERFLOW
`define ALU_FLAG_OVERFLOW 2
`endif
`ifndef ALU_FLAG_NEGATIVE
`define ALU_FLAG_NEGATIVE 3
`endif
`ifndef ALU_ADD
`define ALU_ADD 8'h01
`endif
`ifndef ALU_SUB
`define ALU_SUB 8'h02
`endif
`ifndef ALU_AND
`define ALU_AND 8'h03
`endif
`ifndef ALU_OR
`define ALU_OR 8'h04
`endif
`ifndef ALU_XOR
`define ALU_XOR 8'h05
`endif

// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high; valid holds and its payload stays stable until that edge.
module alu_issue_ctrl #(
    parameter int BUS_SIZE   = 32,
    parameter int FLAG_COUNT = `ALU_FLAG_COUNT,
    parameter int OP_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [OP_WIDTH-1:0]   cmd_op,
    input  logic [BUS_SIZE-1:0]   cmd_a,
    input  logic [BUS_SIZE-1:0]   cmd_b,
    input  logic                  cmd_chain,
    input  logic                  cmd_use_carry,
    output logic [OP_WIDTH-1:0]   alu_op,
    output logic [BUS_SIZE-1:0]   alu_p1,
    output logic [BUS_SIZE-1:0]   alu_p2,
    output logic                  alu_cin,
    input  logic [BUS_SIZE-1:0]   alu_result,
    input  logic [FLAG_COUNT-1:0] alu_flags,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [BUS_SIZE-1:0]   rsp_result,
    output logic [FLAG_COUNT-1:0] rsp_flags,
    output logic [FLAG_COUNT-1:0] sticky_flags,
    input  logic                  sticky_clr,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

    state_t              state;
    logic [BUS_SIZE-1:0] last_result;
    logic                last_carry;

    assign cmd_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            alu_op       <= '0;
            alu_p1       <= '0;
            alu_p2       <= '0;
            alu_cin      <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_flags    <= '0;
            sticky_flags <= '0;
            last_result  <= '0;
            last_carry   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            // A clear coinciding with a capture keeps the freshly captured flags.
            if (sticky_clr) begin
                sticky_flags <= (state == CAPT) ? alu_flags : '0;
            end else if (state == CAPT) begin
                sticky_flags <= sticky_flags | alu_flags;
            end

            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_op  <= cmd_op;
                        alu_p1  <= cmd_chain ? last_result : cmd_a;
                        alu_p2  <= cmd_b;
                        alu_cin <= cmd_use_carry ? last_carry : 1'b0;
                        busy    <= 1'b1;
                        state   <= EXEC;
                    end
                end
                EXEC: state <= CAPT;
                CAPT: begin
                    rsp_result  <= alu_result;
                    rsp_flags   <= alu_flags;
                    last_result <= alu_result;
                    last_carry  <= alu_flags[`ALU_FLAG_CARRY];
                    rsp_valid   <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
